stage_fetch: RTL and testbench

STAGE_FETCH -- requirements
Module: stage_fetch

---
 rtl/tinycpu_fetch_pkg.sv | 23 ++
 rtl/fetch_perf_counters.sv | 29 ++
 rtl/stage_fetch.sv | 148 ++++++++++++++
 tb/tb_stage_fetch.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinycpu_fetch_pkg.sv
// Shared fetch-stage types and constants: state encoding, no-op word and reset PC.
// Used by stage_fetch and, with STAGE_FETCH_PERF_CNT_EN, by fetch_perf_counters.
package tinycpu_fetch_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam word_t NOP_INSTR        = XLEN'(0);
    localparam word_t DEFAULT_RESET_PC = XLEN'(0);

    // Address arithmetic is modulo 2^XLEN; the carry out is discarded on purpose.
    function automatic word_t pc_advance(input word_t pc, input word_t step);
        return pc + step;
    endfunction

endpackage

// File: rtl/fetch_perf_counters.sv
// Fetch performance counters: consumed instructions and decode-stall cycles.
// Only instantiated when STAGE_FETCH_PERF_CNT_EN is defined.
module fetch_perf_counters
    import tinycpu_fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            consume,
    input  logic            stall_cycle,
    output logic [XLEN-1:0] fetch_count,
    output logic [XLEN-1:0] stall_count
);

    // Free-running wrap-around counters, cleared by the synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_count <= XLEN'(0);
            stall_count <= XLEN'(0);
        end else begin
            if (consume) begin
                fetch_count <= fetch_count + XLEN'(1);
            end
            if (stall_cycle) begin
                stall_count <= stall_count + XLEN'(1);
            end
        end
    end

endmodule

// File: rtl/stage_fetch.sv
// Instruction fetch stage: one outstanding imem request, a one-entry holding register
// toward decode, jump redirect with squash. STAGE_FETCH_PERF_CNT_EN adds perf counters.
module stage_fetch
    import tinycpu_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [XLEN-1:0] PC_STEP  = XLEN'(1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            jump_taken,
    input  logic [XLEN-1:0] jump_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] current_instruction,
    output logic [XLEN-1:0] current_pc,
    output logic            squash
`ifdef STAGE_FETCH_PERF_CNT_EN
    ,
    output logic [XLEN-1:0] fetch_count,
    output logic [XLEN-1:0] stall_count
`endif
);

    fetch_state_t    state;
    fetch_state_t    state_next;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] addr_sent;
    logic [XLEN-1:0] ireg;
    logic            drop;

    logic            accept;
    logic            resp;
    logic            capture;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= REQ;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; jump_taken outranks stall, imem_ready and imem_rvalid.
    always_comb begin
        state_next = state;
        case (state)
            REQ: begin
                if (imem_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (jump_taken) begin
                    if (imem_rvalid) begin
                        state_next = REQ;
                    end
                end else if (imem_rvalid) begin
                    state_next = drop ? REQ : HOLD;
                end
            end
            HOLD: begin
                if (jump_taken || !stall) begin
                    state_next = REQ;
                end
            end
            default: state_next = REQ;
        endcase
    end

    // Output and handshake decode; nothing is requested or presented while in reset.
    always_comb begin
        imem_req            = 1'b0;
        imem_addr           = pc;
        current_instruction = NOP_INSTR;
        accept              = 1'b0;
        resp                = 1'b0;
        capture             = 1'b0;
        if (rst) begin
            imem_req = (state == REQ);
            accept   = (state == REQ) && imem_ready;
            resp     = (state == WAIT) && imem_rvalid;
            capture  = resp && !drop && !jump_taken;
            if (state == HOLD) begin
                current_instruction = ireg;
            end
        end
    end

    // Datapath: PC, in-flight address, holding register and drop flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc         <= RESET_PC;
            addr_sent  <= XLEN'(0);
            ireg       <= NOP_INSTR;
            current_pc <= XLEN'(0);
            drop       <= 1'b0;
            squash     <= 1'b0;
        end else begin
            squash <= jump_taken;

            if (jump_taken) begin
                pc <= jump_target;
            end else if (accept) begin
                pc <= pc_advance(pc, PC_STEP);
            end

            if (accept) begin
                addr_sent <= pc;
                drop      <= jump_taken;
            end else if (state == WAIT) begin
                // A response always retires the outstanding request; a jump without one marks it stale.
                drop <= imem_rvalid ? 1'b0 : (drop || jump_taken);
            end

            if (capture) begin
                ireg       <= imem_rdata;
                current_pc <= addr_sent;
            end else if ((state == HOLD) && jump_taken) begin
                ireg <= NOP_INSTR;
            end
        end
    end

`ifdef STAGE_FETCH_PERF_CNT_EN
    logic consume;
    logic stall_cycle;

    assign consume     = rst && (state == HOLD) && !stall && !jump_taken;
    assign stall_cycle = rst && (state == HOLD) && stall;

    fetch_perf_counters u_perf (
        .clk         (clk),
        .rst         (rst),
        .consume     (consume),
        .stall_cycle (stall_cycle),
        .fetch_count (fetch_count),
        .stall_count (stall_count)
    );
`endif

endmodule

// File: tb/tb_stage_fetch.sv
// Self-checking bench for stage_fetch: memory responder, scoreboard of expected
// instructions, directed redirect/reset scenarios and a random phase.
`timescale 1ns/1ps
module tb_stage_fetch;

    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        stall;
    logic        jump_taken;
    logic [31:0] jump_target;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        imem_req,            imem_req_w;
    logic [31:0] imem_addr,           imem_addr_w;
    logic [31:0] current_instruction, current_instruction_w;
    logic [31:0] current_pc,          current_pc_w;
    logic        squash,              squash_w;
`ifdef STAGE_FETCH_PERF_CNT_EN
    logic [31:0] fetch_count, stall_count, fetch_count_w, stall_count_w;
    int          exp_fetch;
    int          exp_stall;
`endif

    stage_fetch u_dut (
        .clk                 (clk),
        .rst                 (rst),
        .stall               (stall),
        .jump_taken          (jump_taken),
        .jump_target         (jump_target),
        .imem_req            (imem_req),
        .imem_addr           (imem_addr),
        .imem_ready          (imem_ready),
        .imem_rvalid         (imem_rvalid),
        .imem_rdata          (imem_rdata),
        .current_instruction (current_instruction),
        .current_pc          (current_pc),
        .squash              (squash)
`ifdef STAGE_FETCH_PERF_CNT_EN
        ,
        .fetch_count         (fetch_count),
        .stall_count         (stall_count)
`endif
    );

    // Second copy reset to the top of the address space to exercise PC wrap.
    stage_fetch #(.RESET_PC(WRAP_PC)) u_wrap (
        .clk                 (clk),
        .rst                 (rst),
        .stall               (stall),
        .jump_taken          (jump_taken),
        .jump_target         (jump_target),
        .imem_req            (imem_req_w),
        .imem_addr           (imem_addr_w),
        .imem_ready          (imem_ready),
        .imem_rvalid         (imem_rvalid),
        .imem_rdata          (imem_rdata),
        .current_instruction (current_instruction_w),
        .current_pc          (current_pc_w),
        .squash              (squash_w)
`ifdef STAGE_FETCH_PERF_CNT_EN
        ,
        .fetch_count         (fetch_count_w),
        .stall_count         (stall_count_w)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          due;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;

    exp_t        exp_q[$];
    rsp_t        rsp_q[$];
    int          vectors  = 0;
    int          errors   = 0;
    int          cyc      = 0;
    int          lat      = 1;
    logic [31:0] exp_pc;
    logic [31:0] exp_pc_w;
    logic        exp_squash;
    logic        holding;
    logic        was_rst;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0001;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_hold(input string tag);
        int n = 0;
        while (current_instruction == 32'h0 && n < 40) begin
            step();
            n++;
        end
        chk(tag, 32'(current_instruction != 32'h0), 32'd1);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!imem_req && n < 40) begin
            step();
            n++;
        end
        chk(tag, 32'(imem_req), 32'd1);
    endtask

    // Memory responder: answers each accepted request after its latency, garbage data otherwise.
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(rsp_q[0].addr);
                rsp_q.delete(0);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'hBAD0_0BAD;
            end
        end
    end

    // Scoreboard: checks outputs mid-cycle, then applies this cycle's events to the expectations.
    initial begin
        exp_pc     = 32'h0;
        exp_pc_w   = WRAP_PC;
        exp_squash = 1'b0;
        holding    = 1'b0;
        was_rst    = 1'b0;
`ifdef STAGE_FETCH_PERF_CNT_EN
        exp_fetch  = 0;
        exp_stall  = 0;
`endif
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("rst_imem_req", 32'(imem_req), 32'd0);
                chk("rst_instr", current_instruction, 32'h0);
`ifdef STAGE_FETCH_PERF_CNT_EN
                if (was_rst) begin
                    chk("rst_fetch_count", fetch_count, 32'd0);
                    chk("rst_stall_count", stall_count, 32'd0);
                end
                exp_fetch = 0;
                exp_stall = 0;
`endif
                exp_q.delete();
                exp_pc     = 32'h0;
                exp_pc_w   = WRAP_PC;
                exp_squash = 1'b0;
                holding    = 1'b0;
                was_rst    = 1'b1;
            end else begin
                if (was_rst) begin
                    chk("rst_cur_pc", current_pc, 32'h0);
                end
                chk("squash", 32'(squash), 32'(exp_squash));
                if (squash) begin
                    chk("squash_nop", current_instruction, 32'h0);
                end
`ifdef STAGE_FETCH_PERF_CNT_EN
                chk("fetch_count", fetch_count, 32'(exp_fetch));
                chk("stall_count", stall_count, 32'(exp_stall));
`endif
                if (current_instruction != 32'h0) begin
                    chk("hold_no_req", 32'(imem_req), 32'd0);
`ifdef STAGE_FETCH_PERF_CNT_EN
                    if (stall) exp_stall++;
                    else if (!jump_taken) exp_fetch++;
`endif
                    if (exp_q.size() == 0) begin
                        chk("unexpected_instr", current_instruction, 32'h0);
                    end else begin
                        chk("instr", current_instruction, exp_q[0].data);
                        chk("cur_pc", current_pc, exp_q[0].addr);
                        if (!holding) begin
                            chk("latency", 32'(cyc), 32'(exp_q[0].due + 1));
                        end
                        holding = 1'b1;
                        if (!stall && !jump_taken) begin
                            exp_q.delete(0);
                            holding = 1'b0;
                        end
                    end
                end
                if (imem_req && imem_ready) begin
                    chk("imem_addr", imem_addr, exp_pc);
                    exp_q.push_back('{exp_pc, mem_word(exp_pc), cyc + lat});
                    rsp_q.push_back('{imem_addr, cyc + lat});
                    exp_pc = exp_pc + 32'd1;
                end
                if (imem_req_w && imem_ready) begin
                    chk("wrap_addr", imem_addr_w, exp_pc_w);
                    exp_pc_w = exp_pc_w + 32'd1;
                end
                if (jump_taken) begin
                    exp_q.delete();
                    holding  = 1'b0;
                    exp_pc   = jump_target;
                    exp_pc_w = jump_target;
                end
                exp_squash = jump_taken;
                was_rst    = 1'b0;
            end
        end
    end

    initial begin
        rst         = 1'b0;
        stall       = 1'b0;
        jump_taken  = 1'b0;
        jump_target = 32'h0;
        imem_ready  = 1'b0;
        step(3);
        chk("init_squash", 32'(squash), 32'd0);
        chk("init_cur_pc", current_pc, 32'h0);

        // Back-to-back stream at minimum latency.
        rst        = 1'b1;
        imem_ready = 1'b1;
        step(12);

        // Decode stall while holding an instruction.
        wait_hold("stall_hold_seen");
        stall = 1'b1;
        step(3);
        stall = 1'b0;
        step(2);

        // Jump while holding.
        wait_hold("jump_hold_seen");
        jump_taken  = 1'b1;
        jump_target = 32'h40;
        step();
        jump_taken  = 1'b0;
        step(6);

        // Jump in WAIT, response two cycles later is stale.
        lat = 2;
        wait_req("jw_req_seen");
        step();
        jump_taken  = 1'b1;
        jump_target = 32'h80;
        step();
        jump_taken  = 1'b0;
        step(8);

        // Jump in WAIT coinciding with the response.
        lat = 1;
        wait_req("jwr_req_seen");
        step();
        jump_taken  = 1'b1;
        jump_target = 32'h100;
        step();
        jump_taken  = 1'b0;
        step(6);

        // Jump in REQ without and with acceptance.
        wait_req("jr0_req_seen");
        imem_ready  = 1'b0;
        jump_taken  = 1'b1;
        jump_target = 32'h200;
        step();
        jump_taken  = 1'b0;
        imem_ready  = 1'b1;
        step(6);
        wait_req("jr1_req_seen");
        jump_taken  = 1'b1;
        jump_target = 32'h300;
        step();
        jump_taken  = 1'b0;
        step(8);

        // Redirect to the last word: next fetches wrap to zero.
        wait_req("wrap_req_seen");
        jump_taken  = 1'b1;
        jump_target = WRAP_PC;
        step();
        jump_taken  = 1'b0;
        step(10);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            imem_ready  = ($urandom_range(0, 9) < 7);
            stall       = ($urandom_range(0, 9) < 3);
            lat         = int'($urandom_range(1, 3));
            jump_taken  = ($urandom_range(0, 19) == 0);
            jump_target = $urandom() & 32'h0FFF_FFFF;
            step();
        end
        stall      = 1'b0;
        jump_taken = 1'b0;
        imem_ready = 1'b1;
        lat        = 1;
        step(10);

        // Reset during WAIT with the response arriving after reset release.
        lat = 3;
        wait_req("rst_req_seen");
        step();
        rst        = 1'b0;
        imem_ready = 1'b0;
        step(2);
        rst = 1'b1;
        step();
        imem_ready = 1'b1;
        step(12);

        // Drain and confirm every fetched instruction was delivered.
        imem_ready = 1'b0;
        step(10);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
